// File: rtl/vga_rx.sv
// vga_rx: VGA timing receiver that locks onto the Hsync/Vsync cadence and emits active pixels with coordinates.
// Optional macro VGA_RX_PULSE_CHECK_EN additionally verifies Hsync/Vsync low-pulse widths.
module vga_rx #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_TOTAL  = 525
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] vgaRed,
  input  logic [2:0] vgaGreen,
  input  logic [1:0] vgaBlue,
  input  logic       Hsync,
  input  logic       Vsync,
  output logic       pix_valid,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic [7:0] pix_data,
  output logic       frame_start,
  output logic       locked,
  output logic       err_hsync,
  output logic       err_vsync
);

  localparam logic [9:0] H_FIRST    = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_LAST     = 10'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [9:0] V_FIRST    = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_LAST     = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [9:0] H_LAST_CNT = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_CNT = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SAT      = 10'd1023;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t     state_q;
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic       armed_q;
  logic [7:0] rgb_q;
  logic [9:0] h_q, v_q;
  logic [9:0] h_d, v_d;
  logic       hs_fall, vs_fall, checking;
  logic       pw_h_err, pw_v_err;
  logic       err_h, err_v, err_any, active;

  // Sync samples reset high so that releasing reset with idle syncs never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= 8'd0;
      h_q       <= 10'd0;
      v_q       <= 10'd0;
    end else begin
      hs_q      <= Hsync;
      vs_q      <= Vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      rgb_q     <= {vgaRed, vgaGreen, vgaBlue};
      h_q       <= h_d;
      v_q       <= v_d;
    end
  end

  // h_d/v_d are the coordinates of the sample currently held in the input registers.
  always_comb begin
    hs_fall  = hs_prev_q & ~hs_q;
    vs_fall  = vs_prev_q & ~vs_q;
    h_d      = hs_fall ? 10'd0 : ((h_q == H_SAT) ? H_SAT : h_q + 10'd1);
    v_d      = vs_fall ? 10'd0 : (hs_fall ? v_q + 10'd1 : v_q);
    checking = (state_q != SEARCH);
`ifdef VGA_RX_PULSE_CHECK_EN
    pw_h_err = hs_q & ~hs_prev_q & (h_d != 10'(H_SYNC));
    pw_v_err = vs_q & ~vs_prev_q & (v_d != 10'(V_SYNC));
`else
    pw_h_err = 1'b0;
    pw_v_err = 1'b0;
`endif
    err_h    = checking & ((hs_fall & armed_q & (h_q != H_LAST_CNT)) | (h_d == H_SAT) | pw_h_err);
    err_v    = checking & ((vs_fall & (v_q != V_LAST_CNT)) | pw_v_err);
    err_any  = err_h | err_v;
    active   = (state_q == LOCKED) & ~err_any &
               (h_d >= H_FIRST) & (h_d <= H_LAST) &
               (v_d >= V_FIRST) & (v_d <= V_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      armed_q     <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= 10'd0;
      pix_y       <= 10'd0;
      pix_data    <= 8'd0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err_hsync   <= 1'b0;
      err_vsync   <= 1'b0;
    end else begin
      err_hsync   <= err_h;
      err_vsync   <= err_v;
      frame_start <= 1'b0;
      pix_valid   <= active;
      if (active) begin
        pix_x    <= h_d - H_FIRST;
        pix_y    <= v_d - V_FIRST;
        pix_data <= rgb_q;
      end
      // The first line after entering MEASURE may be partial, so its end is not length-checked.
      if (checking && hs_fall) armed_q <= 1'b1;
      case (state_q)
        SEARCH: begin
          locked <= 1'b0;
          if (vs_fall) begin
            state_q <= MEASURE;
            armed_q <= 1'b0;
          end
        end
        MEASURE: begin
          if (err_any) begin
            state_q <= SEARCH;
            locked  <= 1'b0;
          end else if (vs_fall) begin
            state_q     <= LOCKED;
            locked      <= 1'b1;
            frame_start <= 1'b1;
          end
        end
        LOCKED: begin
          if (err_any) begin
            state_q <= SEARCH;
            locked  <= 1'b0;
          end else if (vs_fall) begin
            frame_start <= 1'b1;
          end
        end
        default: begin
          state_q <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: directed bench for vga_rx using a scaled-down timing (20 clocks x 10 lines, 8x4 active).
module tb_vga_rx;
  localparam int HA = 8, HS = 4, HB = 3, HT = 20;
  localparam int VA = 4, VS = 2, VB = 2, VT = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] r = 3'd0, g = 3'd0;
  logic [1:0] b = 2'd0;
  logic       hs = 1'b1, vs = 1'b1;
  logic       pix_valid, frame_start, locked, err_hsync, err_vsync;
  logic [9:0] pix_x, pix_y;
  logic [7:0] pix_data;

  always #5 clk = ~clk;

  vga_rx #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vgaRed(r), .vgaGreen(g), .vgaBlue(b),
    .Hsync(hs), .Vsync(vs),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked),
    .err_hsync(err_hsync), .err_vsync(err_vsync)
  );

  int total = 0;
  int bad = 0;

  // Output observers
  int         n_eh = 0, n_ev = 0, n_fs = 0, n_val = 0, n_lock_err = 0, n_fs_bad = 0;
  logic       first_mark = 1'b0;
  logic [9:0] fv_x = 10'd0, fv_y = 10'd0, lv_x = 10'd0, lv_y = 10'd0;
  logic [7:0] fv_d = 8'd0, lv_d = 8'd0;
  logic       prev73 = 1'b0, after73 = 1'b1;

  always @(negedge clk) begin
    if (err_hsync) n_eh <= n_eh + 1;
    if (err_vsync) n_ev <= n_ev + 1;
    if (frame_start) n_fs <= n_fs + 1;
    if ((err_hsync || err_vsync) && locked) n_lock_err <= n_lock_err + 1;
    if (frame_start && !locked) n_fs_bad <= n_fs_bad + 1;
    if (pix_valid) begin
      n_val <= n_val + 1;
      lv_x  <= pix_x;
      lv_y  <= pix_y;
      lv_d  <= pix_data;
      if (!first_mark) begin
        first_mark <= 1'b1;
        fv_x <= pix_x;
        fv_y <= pix_y;
        fv_d <= pix_data;
      end
    end
    if (prev73) after73 <= pix_valid;
    prev73 <= pix_valid && (pix_x == 10'd7) && (pix_y == 10'd3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] col(input int h, input int v);
    if (h == 14 && v == 7) return 8'hA5;
    return 8'(h * 7 + v * 13);
  endfunction

  task automatic drive_line(input int v, input int len, input int hw);
    for (int h = 0; h < len; h++) begin
      @(negedge clk);
      hs = (h < hw) ? 1'b0 : 1'b1;
      vs = (v < VS) ? 1'b0 : 1'b1;
      {r, g, b} = col(h, v);
    end
  endtask

  task automatic drive_frame(input int nl, input int bad_v, input int bad_len, input int bad_hw);
    for (int v = 0; v < nl; v++)
      drive_line(v, (v == bad_v) ? bad_len : HT, (v == bad_v) ? bad_hw : HS);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hs = 1'b1;
      vs = 1'b1;
    end
  endtask

  int s_fs, s_val, s_eh, s_ev;

  task automatic snap();
    s_fs = n_fs; s_val = n_val; s_eh = n_eh; s_ev = n_ev;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #2;
    check("rst_locked", locked, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_fs", frame_start, 0);
    check("rst_errh", err_hsync, 0);
    check("rst_errv", err_vsync, 0);
    check("rst_x", pix_x, 0);
    check("rst_y", pix_y, 0);
    check("rst_data", pix_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // Frame A: search -> measure
    snap();
    drive_frame(VT, -1, 0, 0); #2;
    check("A_locked", locked, 0);
    check("A_fs", n_fs - s_fs, 0);

    // Frame B: locks at its Vsync edge, full active window visible
    snap();
    drive_frame(VT, -1, 0, 0); #2;
    check("B_locked", locked, 1);
    check("B_fs", n_fs - s_fs, 1);
    check("B_nvalid", n_val - s_val, HA * VA);
    check("B_first_x", fv_x, 0);
    check("B_first_y", fv_y, 0);
    check("B_first_d", fv_d, 8'h65);
    check("B_last_x", lv_x, 7);
    check("B_last_y", lv_y, 3);
    check("B_last_d", lv_d, 8'hA5);
    check("B_after_last", after73, 0);
    check("B_hold_valid", pix_valid, 0);
    check("B_hold_x", pix_x, 7);
    check("B_hold_d", pix_data, 8'hA5);
    check("B_errs", (n_eh - s_eh) + (n_ev - s_ev), 0);

    // Frame C clean, frame D has one 21-clock line
    drive_frame(VT, -1, 0, 0);
    snap();
    drive_frame(VT, 5, HT + 1, HS); #2;
    check("D_errh", n_eh - s_eh, 1);
    check("D_errv", n_ev - s_ev, 0);
    check("D_locked", locked, 0);
    snap();
    drive_frame(VT, -1, 0, 0); #2;
    check("E_locked", locked, 0);
    check("E_novalid", n_val - s_val, 0);
    snap();
    drive_frame(VT, -1, 0, 0); #2;
    check("F_locked", locked, 1);
    check("F_fs", n_fs - s_fs, 1);

    // Frame G one line short, error at frame H's Vsync edge
    snap();
    drive_frame(VT - 1, -1, 0, 0);
    drive_frame(VT, -1, 0, 0); #2;
    check("H_errv", n_ev - s_ev, 1);
    check("H_errh", n_eh - s_eh, 0);
    check("H_locked", locked, 0);
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT, -1, 0, 0); #2;
    check("J_locked", locked, 1);

    // Hsync stuck high
    snap();
    idle(1030); #2;
    check("stuck_errh", n_eh - s_eh, 1);
    check("stuck_locked", locked, 0);
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT, -1, 0, 0); #2;
    check("L_locked", locked, 1);

    // Short Hsync pulse
    snap();
    drive_frame(VT, 3, HT, HS - 1); #2;
`ifdef VGA_RX_PULSE_CHECK_EN
    check("M_errh", n_eh - s_eh, 1);
    check("M_locked", locked, 0);
`else
    check("M_errh", n_eh - s_eh, 0);
    check("M_locked", locked, 1);
`endif
    drive_frame(VT, -1, 0, 0);
    drive_frame(VT, -1, 0, 0);
    for (int v = 0; v < 5; v++) drive_line(v, HT, HS);
    #2;
    check("pre_rst_locked", locked, 1);
    check("pre_rst_x", pix_x, 7);
    rst_n = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_x", pix_x, 0);
    check("async_y", pix_y, 0);
    check("async_data", pix_data, 0);
    check("async_valid", pix_valid, 0);
    repeat (2) @(negedge clk);
    hs = 1'b1;
    vs = 1'b1;
    rst_n = 1'b1;
    snap();
    idle(5);
    drive_frame(VT, -1, 0, 0); #2;
    check("O_locked", locked, 0);
    check("O_errs", (n_eh - s_eh) + (n_ev - s_ev), 0);
    snap();
    drive_frame(VT, -1, 0, 0); #2;
    check("P_locked", locked, 1);
    check("P_fs", n_fs - s_fs, 1);
    check("P_errs", (n_eh - s_eh) + (n_ev - s_ev), 0);

    check("lock_during_err", n_lock_err, 0);
    check("fs_unlocked", n_fs_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_SYNC, default 96, Hsync low width in clocks.
REQ-003 SHALL have parameter H_BACK, default 48, back porch in clocks.
REQ-004 SHALL have parameter H_TOTAL, default 800, clocks per line.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_SYNC, default 2, Vsync low width in lines.
REQ-007 SHALL have parameter V_BACK, default 33, back porch in lines.
REQ-008 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-009 SHALL have port clk, input, 1, pixel clock: one pixel per rising edge.
REQ-010 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-011 SHALL have ports vgaRed, vgaGreen and vgaBlue, input, 3/3/2, sampled pixel colour.
REQ-012 SHALL have ports Hsync and Vsync, input, 1 each, active-low sync pulses.
REQ-013 SHALL have port pix_valid, output, 1, high when the pix_* outputs hold an active pixel.
REQ-014 SHALL have port pix_x, output, 10, active column 0..H_ACTIVE-1.
REQ-015 SHALL have port pix_y, output, 10, active row 0..V_ACTIVE-1.
REQ-016 SHALL have port pix_data, output, 8, {R,G,B} colour of the pixel.
REQ-017 SHALL have port frame_start, output, 1, one-cycle pulse marking the start of a frame.
REQ-018 SHALL have port locked, output, 1, high while the incoming timing is verified.
REQ-019 SHALL have ports err_hsync and err_vsync, output, 1 each, one-cycle error pulses.

Function
REQ-020 SHALL register every input once; all decoding uses the registered samples.
REQ-021 SHALL detect a falling edge when the current sample is 0 and the previous sample is 1.
REQ-022 SHALL run horizontal counter h: set to 0 on an Hsync falling edge, otherwise increment, saturating at 1023.
REQ-023 SHALL run line counter v: set to 0 on a Vsync falling edge, otherwise increment on each Hsync falling edge.
REQ-024 SHALL handle coincident Hsync and Vsync falling edges by giving h=0 and v=0.
REQ-025 SHALL implement FSM SEARCH -> MEASURE -> LOCKED.
REQ-026 SHALL move SEARCH -> MEASURE on a Vsync falling edge.
REQ-027 SHALL move MEASURE -> LOCKED on the next Vsync falling edge if no error occurred in between.
REQ-028 SHALL apply a line check from the second Hsync falling edge after entering MEASURE: h must equal H_TOTAL-1 at the edge; otherwise pulse err_hsync and go to SEARCH.
REQ-029 SHALL apply a frame check at each Vsync falling edge in MEASURE or LOCKED: v must equal V_TOTAL-1; otherwise pulse err_vsync and go to SEARCH.
REQ-030 SHALL treat h reaching 1023 in MEASURE or LOCKED as a missing Hsync: pulse err_hsync and go to SEARCH.
REQ-031 SHALL drive locked=1 only in LOCKED.
REQ-032 SHALL pulse frame_start for one cycle on each Vsync falling edge processed in LOCKED, including the transition into LOCKED.
REQ-033 SHALL treat a sample as active when in LOCKED with h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1].
REQ-034 SHALL, for an active sample, present x=h-(H_SYNC+H_BACK), y=v-(V_SYNC+V_BACK) and the colour on the pix_* outputs one clock after that sample is registered, with pix_valid=1.
REQ-035 SHALL hold pix_valid=0 and the previous pix_x, pix_y and pix_data values outside active samples.
REQ-036 SHALL give error pulses priority over frame_start in the same cycle, with locked falling in the same cycle as the error pulse.

Reset
REQ-037 SHALL, while rst_n=0, immediately force state SEARCH, h=0, v=0, Hsync/Vsync sample registers to 1, and every output to 0; operation resumes on the first clk edge after rst_n=1.

Configuration
REQ-038 SHALL, with VGA_RX_PULSE_CHECK_EN defined, also check in MEASURE and LOCKED that each Hsync low pulse lasts exactly H_SYNC clocks (pulse err_hsync and go to SEARCH otherwise) and each Vsync low pulse spans exactly V_SYNC Hsync falling edges (pulse err_vsync and go to SEARCH otherwise); without the macro, pulse widths SHALL be ignored.

Verification
REQ-039 Two clean 640x480 frames -> locked=1 and frame_start pulses at the second Vsync falling edge; the sample at h=144, v=35 gives pix_x=0, pix_y=0, pix_valid=1.
REQ-040 Drive 8'hA5 at the sample h=783, v=514 in LOCKED -> pix_data=8'hA5, pix_x=639, pix_y=479, then pix_valid=0 on the next cycle.
REQ-041 One 801-clock line while LOCKED -> single err_hsync pulse, locked=0, no pix_valid until relocked two Vsync falling edges later.
REQ-042 One 524-line frame while LOCKED -> err_vsync pulse, locked=0; Hsync held high for 1024 clocks -> err_hsync pulse.
REQ-043 95-clock Hsync pulse while LOCKED -> err_hsync pulse with VGA_RX_PULSE_CHECK_EN defined; locked stays 1 without it.
REQ-044 rst_n pulsed low mid-frame -> all outputs 0 immediately; relock after two Vsync falling edges with no spurious edge detected at reset release.
